// File: rtl/alu4_acc_sequencer_if.sv
// Command and result valid/ready channels of the ALU accumulator sequencer.
// The upstream/consumer side uses master; the sequencer uses slave.
interface alu4_acc_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_opnd;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             res_neg;
  logic             res_err;

  modport master (
    output cmd_valid, cmd_op, cmd_opnd, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, res_neg, res_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_opnd, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_neg, res_err
  );
endinterface

// File: rtl/alu4_acc_sequencer.sv
// Sequencer around an external combinational ALU: takes one command per handshake,
// updates the accumulator from alu_z/operand and returns the result with flags.
module alu4_acc_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu4_acc_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_ctl,
  input  logic [WIDTH-1:0]     alu_z,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_LOAD = 3'd3,
    OP_SUB  = 3'd4,
    OP_CLR  = 3'd5,
    OP_RSVD = 3'd6,
    OP_XNOR = 3'd7
  } op_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_is_alu;

  always_comb begin
    op_is_alu = 1'b0;
    case (op_q)
      OP_ADD, OP_NAND, OP_OR, OP_SUB, OP_XNOR: op_is_alu = 1'b1;
      default:                                 op_is_alu = 1'b0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      acc_q   <= '0;
      opnd_q  <= '0;
      zero_q  <= 1'b1;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = op_e'(bus.cmd_op);
          opnd_d  = bus.cmd_opnd;
          err_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_LOAD: acc_d = opnd_q;
          OP_CLR:  acc_d = '0;
          OP_RSVD: acc_d = acc_q;
          default: acc_d = alu_z;
        endcase
        // Flags are taken from the value being written so they line up with res_data in RESP.
        zero_d  = (acc_d == '0);
        neg_d   = acc_d[WIDTH-1];
        err_d   = (op_q == OP_RSVD);
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.cmd_ready = rst_n && (state_q == IDLE);
    bus.res_valid = (state_q == RESP);
    bus.res_data  = acc_q;
    bus.res_zero  = zero_q;
    bus.res_neg   = neg_q;
    bus.res_err   = err_q;
    alu_a         = acc_q;
    alu_b         = opnd_q;
    alu_ctl       = ((state_q == EXEC) && op_is_alu) ? 3'(op_q) : '0;
    op_count      = cnt_q;
  end

endmodule

// File: tb/tb_alu4_acc_sequencer.sv
// Scoreboard bench for alu4_acc_sequencer: a driver pushes expected results from a
// behavioural accumulator model; a monitor pops and compares on result handshakes.
module tb_alu4_acc_sequencer;
  localparam int W  = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu4_acc_sequencer_if #(.WIDTH(W)) bus ();
  logic [W-1:0]  alu_a, alu_b, alu_z;
  logic [2:0]    alu_ctl;
  logic [CW-1:0] op_count;

  alu4_acc_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctl  (alu_ctl),
    .alu_z    (alu_z),
    .op_count (op_count)
  );

  // External 4-bit combinational ALU
  always_comb begin
    case (alu_ctl)
      3'd0:    alu_z = 4'(alu_a + alu_b);
      3'd1:    alu_z = ~(alu_a & alu_b);
      3'd2:    alu_z = alu_a | alu_b;
      3'd4:    alu_z = 4'(alu_a - alu_b);
      3'd7:    alu_z = ~(alu_a ^ alu_b);
      default: alu_z = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    logic [3:0] data;
    logic       zero;
    logic       neg;
    logic       err;
    logic [3:0] opnd;
    logic [2:0] ctl;
    int         acc_cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         rr_mode = 0;
  logic [3:0] m_acc = '0;
  logic [7:0] m_cnt = '0;
  logic [7:0] mon_cnt = '0;
  bit         seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model(input int op, input int a, input int b, output logic err);
    err = 1'b0;
    case (op)
      0: return (a + b) % 16;
      1: return 15 - (a & b);
      2: return a | b;
      3: return b;
      4: return (a - b + 16) % 16;
      5: return 0;
      6: begin err = 1'b1; return a; end
      default: return 15 - (a ^ b);
    endcase
  endfunction

  // Consumer readiness
  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.res_ready = 1'b1;
        1:       bus.res_ready = 1'b0;
        default: bus.res_ready = ($urandom_range(3) != 0);
      endcase
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      seen = 1'b0;
      mon_cnt = '0;
    end else begin
      if (sb.size() > 0 && !seen && cyc == sb[0].acc_cyc) begin
        check("alu_ctl_exec", alu_ctl, sb[0].ctl);
        check("alu_b_exec", alu_b, sb[0].opnd);
      end
      if (bus.res_valid) begin
        if (sb.size() == 0) begin
          check("res_valid_unexpected", bus.res_valid, 0);
        end else begin
          if (!seen) begin
            check("latency", cyc, sb[0].acc_cyc + 1);
            seen = 1'b1;
          end
          check("res_data", bus.res_data, sb[0].data);
          check("res_zero", bus.res_zero, sb[0].zero);
          check("res_neg", bus.res_neg, sb[0].neg);
          check("res_err", bus.res_err, sb[0].err);
          check("alu_a_resp", alu_a, sb[0].data);
          check("alu_ctl_resp", alu_ctl, 0);
          check("cmd_ready_resp", bus.cmd_ready, 0);
          check("op_count", op_count, mon_cnt);
          if (bus.res_ready) begin
            void'(sb.pop_front());
            seen = 1'b0;
            mon_cnt++;
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [3:0] b, output int acyc);
    exp_t e;
    int   n = 0;
    int   r;
    logic err;
    acyc = -1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_opnd  = b;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_ready_timeout", bus.cmd_ready, 1);
    end else begin
      r         = model(int'(op), int'(m_acc), int'(b), err);
      e.data    = r[3:0];
      e.zero    = (r == 0);
      e.neg     = (r >= 8);
      e.err     = err;
      e.opnd    = b;
      e.ctl     = (op == 3'd3 || op == 3'd5 || op == 3'd6) ? 3'd0 : op;
      e.acc_cyc = cyc + 1;
      sb.push_back(e);
      m_acc = r[3:0];
      m_cnt++;
      acyc = cyc + 1;
      @(posedge clk);
    end
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_opnd  = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_queue_empty", sb.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_data"}, bus.res_data, 0);
    check({tag, "_res_zero"}, bus.res_zero, 1);
    check({tag, "_res_neg"}, bus.res_neg, 0);
    check({tag, "_res_err"}, bus.res_err, 0);
    check({tag, "_op_count"}, op_count, 0);
    check({tag, "_alu_ctl"}, alu_ctl, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, t;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_opnd  = '0;
    rst_n = 1'b0;

    #12;
    check_reset("reset");
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", bus.cmd_ready, 1);

    // LOAD 5, ADD 3, SUB 9 back to back with res_ready held high
    rr_mode = 0;
    issue(3'd3, 4'h5, a0);
    issue(3'd0, 4'h3, a1);
    issue(3'd4, 4'h9, a2);
    check("throughput_gap1", a1 - a0, 3);
    check("throughput_gap2", a2 - a1, 3);
    drain();

    // Logic ops and CLR
    issue(3'd3, 4'hC, t);
    issue(3'd1, 4'hA, t);
    issue(3'd2, 4'h8, t);
    issue(3'd7, 4'h5, t);
    issue(3'd5, 4'h0, t);
    drain();

    // Consumer stall: result held, no command taken
    rr_mode = 1;
    issue(3'd3, 4'h2, t);
    for (int i = 0; i < 20 && !bus.res_valid; i++) @(negedge clk);
    check("stall_res_valid", bus.res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_cmd_ready", bus.cmd_ready, 0);
      bus.cmd_valid = (i == 4);
      bus.cmd_op    = 3'd3;
      bus.cmd_opnd  = 4'($urandom);
    end
    bus.cmd_valid = 1'b0;
    rr_mode = 0;
    drain();
    check("stall_op_count", op_count, m_cnt);

    // Reserved opcode, then error clears on the next command
    issue(3'd3, 4'h4, t);
    issue(3'd6, 4'($urandom), t);
    issue(3'd0, 4'h1, t);
    drain();

    // Asynchronous reset in the middle of EXEC
    issue(3'd3, 4'h9, t);
    #1 rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    m_acc = '0;
    m_cnt = '0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_res_after_reset", bus.res_valid, 0);
    end

    // Random traffic long enough to wrap op_count
    rr_mode = 2;
    for (int i = 0; i < 260; i++) begin
      issue(3'($urandom_range(7)), 4'($urandom_range(15)), t);
    end
    rr_mode = 0;
    drain();
    check("wrap_op_count", op_count, m_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
